// File: rtl/obi2ahb_pkg.sv
// Shared AHB-Lite encodings, bridge FSM states, port identifiers and the
// address-phase control payload for the dual OBI to AHB-Lite bridge.
package obi2ahb_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_ERR2,
      ST_LERR
   } state_e;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   // Address-phase control held between transfers
   typedef struct packed {
      logic       hwrite;
      logic [2:0] hsize;
      logic [3:0] hprot;
   } ahb_ctrl_t;

endpackage

// File: rtl/obi2ahb_be2size.sv
// OBI byte-enable to AHB hsize mapping (pure combinational).
// Ports: be (byte enables), hsize_c (AHB transfer size), legal_c (pattern
// is a naturally aligned byte, halfword or word).
module obi2ahb_be2size
   import obi2ahb_pkg::*;
(
   input  logic [3:0] be,
   output logic [2:0] hsize_c,
   output logic       legal_c
);

   always_comb begin
      hsize_c = HSIZE_BYTE;
      legal_c = 1'b1;
      unique case (be)
         4'b1111:                            hsize_c = HSIZE_WORD;
         4'b0011, 4'b1100:                   hsize_c = HSIZE_HALF;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: hsize_c = HSIZE_BYTE;
         default:                            legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/obi2ahb_dual_bridge.sv
// Dual OBI (instruction + data) to single AHB-Lite master bridge.
// One AHB data phase outstanding at most; grants and the address phase are
// combinational in the accept window, responses are returned combinationally
// in the completing data-phase cycle.
// Ports: hclk_i/hresetn_i clock and async active-low reset; h* AHB-Lite
// master; i_* instruction OBI (read only); d_* data OBI; priv_mode_i drives
// hprot_o[1].
// Build option: OBI2AHB_RR_ARB_EN selects round-robin arbitration; without
// it the data port wins on contention.
module obi2ahb_dual_bridge
   import obi2ahb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter logic [1:0]  HPROT_CACHE = 2'b00
)
(
   input  logic              hclk_i,
   input  logic              hresetn_i,
   // AHB-Lite master
   output logic [ADDR_W-1:0] haddr_o,
   output logic [1:0]        htrans_o,
   output logic              hwrite_o,
   output logic [2:0]        hsize_o,
   output logic [2:0]        hburst_o,
   output logic [3:0]        hprot_o,
   output logic              hmastlock_o,
   output logic [31:0]       hwdata_o,
   input  logic [31:0]       hrdata_i,
   input  logic              hready_i,
   input  logic              hresp_i,
   // OBI instruction port
   input  logic              i_req_i,
   output logic              i_gnt_o,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_rvalid_o,
   output logic [31:0]       i_rdata_o,
   output logic              i_err_o,
   // OBI data port
   input  logic              d_req_i,
   output logic              d_gnt_o,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic              d_we_i,
   input  logic [3:0]        d_be_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_rvalid_o,
   output logic [31:0]       d_rdata_o,
   output logic              d_err_o,
   // privilege
   input  logic              priv_mode_i
);

   localparam ahb_ctrl_t CTRL_RST = '{hwrite: 1'b0, hsize: HSIZE_BYTE,
                                      hprot: {HPROT_CACHE, 2'b11}};

   state_e               state_q, state_d;
   port_e                owner_q, owner_d;
   ahb_ctrl_t            ctrl_q, ctrl_d;
   logic [ADDR_W-1:0]    haddr_q, haddr_d;
   logic [DATA_W-1:0]    hwdata_q, hwdata_d;

   logic [2:0]           d_size_c;
   logic                 d_legal_c;
   logic                 accept_c;
   logic                 data_wins_c;
   logic                 i_gnt_c, d_gnt_c;
   logic [1:0]           htrans_c;
   logic                 rsp_valid_c, rsp_err_c;
   logic [DATA_W-1:0]    rsp_data_c;

   obi2ahb_be2size u_be2size (
      .be      (d_be_i),
      .hsize_c (d_size_c),
      .legal_c (d_legal_c)
   );

   // New grants only when idle or when the current data phase completes OK
   assign accept_c = (state_q == ST_IDLE) ||
                     ((state_q == ST_DATA) && hready_i && !hresp_i);

`ifdef OBI2AHB_RR_ARB_EN
   // rr_q names the port that wins the next contention
   port_e rr_q, rr_d;
   assign data_wins_c = (rr_q == PORT_DATA);
`else
   assign data_wins_c = 1'b1;
`endif

   // State and held address-phase registers
   always_ff @(posedge hclk_i or negedge hresetn_i) begin
      if (!hresetn_i) begin
         state_q  <= ST_IDLE;
         owner_q  <= PORT_DATA;
         ctrl_q   <= CTRL_RST;
         haddr_q  <= '0;
         hwdata_q <= '0;
`ifdef OBI2AHB_RR_ARB_EN
         rr_q     <= PORT_DATA;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ctrl_q   <= ctrl_d;
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
`ifdef OBI2AHB_RR_ARB_EN
         rr_q     <= rr_d;
`endif
      end
   end

   // Next state, response and grant/address-phase logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ctrl_d      = ctrl_q;
      haddr_d     = haddr_q;
      hwdata_d    = hwdata_q;
`ifdef OBI2AHB_RR_ARB_EN
      rr_d        = rr_q;
`endif
      i_gnt_c     = 1'b0;
      d_gnt_c     = 1'b0;
      htrans_c    = HTRANS_IDLE;
      rsp_valid_c = 1'b0;
      rsp_err_c   = 1'b0;
      rsp_data_c  = '0;

      unique case (state_q)
         ST_IDLE: ;
         ST_DATA: begin
            if (hready_i && !hresp_i) begin
               rsp_valid_c = 1'b1;
               rsp_data_c  = ctrl_q.hwrite ? '0 : hrdata_i;
               state_d     = ST_IDLE;
            end else if (hready_i && hresp_i) begin
               // error seen only in its final cycle: still report it
               rsp_valid_c = 1'b1;
               rsp_err_c   = 1'b1;
               state_d     = ST_IDLE;
            end else if (hresp_i) begin
               state_d = ST_ERR2;
            end
         end
         ST_ERR2: begin
            if (hready_i) begin
               rsp_valid_c = 1'b1;
               rsp_err_c   = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_LERR: begin
            rsp_valid_c = 1'b1;
            rsp_err_c   = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept_c && d_req_i && (data_wins_c || !i_req_i)) begin
         d_gnt_c = 1'b1;
         owner_d = PORT_DATA;
`ifdef OBI2AHB_RR_ARB_EN
         rr_d    = PORT_INSTR;
`endif
         if (d_legal_c) begin
            htrans_c = HTRANS_NONSEQ;
            haddr_d  = d_addr_i;
            ctrl_d   = '{hwrite: d_we_i, hsize: d_size_c,
                         hprot: {HPROT_CACHE, priv_mode_i, 1'b1}};
            if (d_we_i) hwdata_d = d_wdata_i;
            state_d  = ST_DATA;
         end else begin
            // illegal byte enables: accepted but never reach the bus
            state_d = ST_LERR;
         end
      end else if (accept_c && i_req_i) begin
         i_gnt_c  = 1'b1;
         owner_d  = PORT_INSTR;
`ifdef OBI2AHB_RR_ARB_EN
         rr_d     = PORT_DATA;
`endif
         htrans_c = HTRANS_NONSEQ;
         haddr_d  = i_addr_i & ~ADDR_W'(3);
         ctrl_d   = '{hwrite: 1'b0, hsize: HSIZE_WORD,
                      hprot: {HPROT_CACHE, priv_mode_i, 1'b0}};
         state_d  = ST_DATA;
      end
   end

   // AHB outputs: live address phase on a grant, held values otherwise
   assign htrans_o    = htrans_c;
   assign haddr_o     = haddr_d;
   assign hwrite_o    = ctrl_d.hwrite;
   assign hsize_o     = ctrl_d.hsize;
   assign hprot_o     = ctrl_d.hprot;
   assign hburst_o    = HBURST_SINGLE;
   assign hmastlock_o = 1'b0;
   assign hwdata_o    = hwdata_q;

   // OBI outputs: the response is steered to the port owning the data phase
   assign i_gnt_o    = i_gnt_c;
   assign d_gnt_o    = d_gnt_c;
   assign i_rvalid_o = rsp_valid_c && (owner_q == PORT_INSTR);
   assign i_err_o    = rsp_err_c   && (owner_q == PORT_INSTR);
   assign i_rdata_o  = (owner_q == PORT_INSTR) ? rsp_data_c : '0;
   assign d_rvalid_o = rsp_valid_c && (owner_q == PORT_DATA);
   assign d_err_o    = rsp_err_c   && (owner_q == PORT_DATA);
   assign d_rdata_o  = (owner_q == PORT_DATA) ? rsp_data_c : '0;

endmodule

// File: tb/tb_obi2ahb_dual_bridge.sv
// Directed self-checking bench for obi2ahb_dual_bridge.
module tb_obi2ahb_dual_bridge;

   localparam int unsigned ADDR_W   = 32;
   localparam logic [1:0]  TB_CACHE = 2'b10;

   logic              hclk_i, hresetn_i;
   logic [ADDR_W-1:0] haddr_o;
   logic [1:0]        htrans_o;
   logic              hwrite_o;
   logic [2:0]        hsize_o, hburst_o;
   logic [3:0]        hprot_o;
   logic              hmastlock_o;
   logic [31:0]       hwdata_o, hrdata_i;
   logic              hready_i, hresp_i;
   logic              i_req_i, i_gnt_o, i_rvalid_o, i_err_o;
   logic [ADDR_W-1:0] i_addr_i;
   logic [31:0]       i_rdata_o;
   logic              d_req_i, d_gnt_o, d_we_i, d_rvalid_o, d_err_o;
   logic [ADDR_W-1:0] d_addr_i;
   logic [3:0]        d_be_i;
   logic [31:0]       d_wdata_i, d_rdata_o;
   logic              priv_mode_i;

   int n_tests = 0;
   int n_fail  = 0;

   obi2ahb_dual_bridge #(.ADDR_W(ADDR_W), .HPROT_CACHE(TB_CACHE)) dut (
      .hclk_i(hclk_i), .hresetn_i(hresetn_i),
      .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
      .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
      .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o), .hrdata_i(hrdata_i),
      .hready_i(hready_i), .hresp_i(hresp_i),
      .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
      .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i),
      .d_we_i(d_we_i), .d_be_i(d_be_i), .d_wdata_i(d_wdata_i),
      .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .priv_mode_i(priv_mode_i)
   );

   initial hclk_i = 1'b0;
   always #5 hclk_i = ~hclk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge; checks follow #4 later
   task automatic cyc();
      @(posedge hclk_i);
      #1;
   endtask

   task automatic apply_reset();
      hresetn_i = 1'b0;
      i_req_i = 1'b0; d_req_i = 1'b0;
      hready_i = 1'b1; hresp_i = 1'b0;
      repeat (2) @(posedge hclk_i);
      #1;
      hresetn_i = 1'b1;
   endtask

   task automatic test_reset();
      hresetn_i = 1'b0;
      repeat (2) @(posedge hclk_i);
      #1;
      n_tests++; if (htrans_o !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %0h exp 0", htrans_o); end
      n_tests++; if (haddr_o !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %0h exp 0", haddr_o); end
      n_tests++; if (hprot_o !== 4'b1011) begin n_fail++; $display("FAIL rst_hprot: got %0b exp 1011", hprot_o); end
      n_tests++; if ({hwrite_o, hsize_o, hwdata_o} !== 36'h0) begin n_fail++; $display("FAIL rst_ctrl: got %0b/%0h/%0h exp 0", hwrite_o, hsize_o, hwdata_o); end
      n_tests++; if ({hburst_o, hmastlock_o} !== 4'b0) begin n_fail++; $display("FAIL rst_burst_lock: got %0h/%0b exp 0", hburst_o, hmastlock_o); end
      n_tests++; if ({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o} !== 4'b0) begin n_fail++; $display("FAIL rst_obi: got %0b%0b%0b%0b exp 0000", i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o); end
      hresetn_i = 1'b1;
   endtask

   task automatic test_write_half();
      cyc(); d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b1100; d_addr_i = 32'h1002;
      d_wdata_i = 32'hDEADBEEF; hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'h12345678; #4;
      n_tests++; if (d_gnt_o !== 1'b1 || i_gnt_o !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got d=%0b i=%0b exp d=1 i=0", d_gnt_o, i_gnt_o); end
      n_tests++; if (htrans_o !== 2'b10 || hsize_o !== 3'b001) begin n_fail++; $display("FAIL wr_addrphase: got htrans=%0h hsize=%0h exp 2/1", htrans_o, hsize_o); end
      n_tests++; if (haddr_o !== 32'h1002 || hwrite_o !== 1'b1) begin n_fail++; $display("FAIL wr_haddr: got %0h w=%0b exp 1002 w=1", haddr_o, hwrite_o); end
      n_tests++; if (hprot_o !== 4'b1011) begin n_fail++; $display("FAIL wr_hprot: got %0b exp 1011", hprot_o); end
      cyc(); d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'b1111; #4;
      n_tests++; if (hwdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hwdata: got %0h exp deadbeef", hwdata_o); end
      n_tests++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b0 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL wr_rsp: got v=%0b e=%0b d=%0h exp 1/0/0", d_rvalid_o, d_err_o, d_rdata_o); end
      n_tests++; if (htrans_o !== 2'b00 || i_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got htrans=%0h i_rvalid=%0b exp 0/0", htrans_o, i_rvalid_o); end
   endtask

   task automatic test_instr_b2b();
      cyc(); i_req_i = 1'b1; i_addr_i = 32'h0; hready_i = 1'b1; #4;
      n_tests++; if (i_gnt_o !== 1'b1 || htrans_o !== 2'b10 || haddr_o !== 32'h0) begin n_fail++; $display("FAIL ib_gnt0: got g=%0b t=%0h a=%0h exp 1/2/0", i_gnt_o, htrans_o, haddr_o); end
      n_tests++; if (hsize_o !== 3'b010 || hwrite_o !== 1'b0 || hprot_o !== 4'b1010) begin n_fail++; $display("FAIL ib_ctrl0: got s=%0h w=%0b p=%0b exp 2/0/1010", hsize_o, hwrite_o, hprot_o); end
      cyc(); i_addr_i = 32'h4; hready_i = 1'b0; #4;
      n_tests++; if (i_gnt_o !== 1'b0 || htrans_o !== 2'b00 || i_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ib_wait1: got g=%0b t=%0h v=%0b exp 0/0/0", i_gnt_o, htrans_o, i_rvalid_o); end
      cyc(); #4;
      n_tests++; if (i_rvalid_o !== 1'b0 || haddr_o !== 32'h0) begin n_fail++; $display("FAIL ib_wait2: got v=%0b a=%0h exp 0/0", i_rvalid_o, haddr_o); end
      cyc(); hready_i = 1'b1; hrdata_i = 32'h11111111; #4;
      n_tests++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 32'h11111111 || i_err_o !== 1'b0) begin n_fail++; $display("FAIL ib_rsp0: got v=%0b d=%0h e=%0b exp 1/11111111/0", i_rvalid_o, i_rdata_o, i_err_o); end
      n_tests++; if (i_gnt_o !== 1'b1 || htrans_o !== 2'b10 || haddr_o !== 32'h4) begin n_fail++; $display("FAIL ib_gnt1: got g=%0b t=%0h a=%0h exp 1/2/4", i_gnt_o, htrans_o, haddr_o); end
      cyc(); i_req_i = 1'b0; hready_i = 1'b0; #4;
      n_tests++; if (i_rvalid_o !== 1'b0 || i_rdata_o !== 32'h0) begin n_fail++; $display("FAIL ib_wait3: got v=%0b d=%0h exp 0/0", i_rvalid_o, i_rdata_o); end
      cyc(); #4;
      cyc(); hready_i = 1'b1; hrdata_i = 32'h22222222; #4;
      n_tests++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 32'h22222222 || d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ib_rsp1: got v=%0b d=%0h dv=%0b exp 1/22222222/0", i_rvalid_o, i_rdata_o, d_rvalid_o); end
   endtask

   task automatic test_byte_user();
      cyc(); priv_mode_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b0100; d_addr_i = 32'h3001; #4;
      n_tests++; if (d_gnt_o !== 1'b1 || haddr_o !== 32'h3001 || hsize_o !== 3'b000) begin n_fail++; $display("FAIL by_addr: got g=%0b a=%0h s=%0h exp 1/3001/0", d_gnt_o, haddr_o, hsize_o); end
      n_tests++; if (hprot_o !== 4'b1001 || hwrite_o !== 1'b0) begin n_fail++; $display("FAIL by_hprot: got p=%0b w=%0b exp 1001/0", hprot_o, hwrite_o); end
      cyc(); d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h107; hrdata_i = 32'hA5A5A5A5; #4;
      n_tests++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL by_rsp: got v=%0b d=%0h exp 1/a5a5a5a5", d_rvalid_o, d_rdata_o); end
      n_tests++; if (i_gnt_o !== 1'b1 || haddr_o !== 32'h104 || hsize_o !== 3'b010 || hprot_o !== 4'b1000) begin n_fail++; $display("FAIL ia_align: got g=%0b a=%0h s=%0h p=%0b exp 1/104/2/1000", i_gnt_o, haddr_o, hsize_o, hprot_o); end
      n_tests++; if (hwdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hwdata_hold: got %0h exp deadbeef", hwdata_o); end
      cyc(); i_req_i = 1'b0; hrdata_i = 32'h5A5A5A5A; priv_mode_i = 1'b1; #4;
      n_tests++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 32'h5A5A5A5A || d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL ia_rsp: got iv=%0b id=%0h dv=%0b dd=%0h exp 1/5a5a5a5a/0/0", i_rvalid_o, i_rdata_o, d_rvalid_o, d_rdata_o); end
   endtask

   task automatic test_slave_err();
      cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b1111; d_addr_i = 32'h2000; hrdata_i = 32'hFFFFFFFF; #4;
      n_tests++; if (d_gnt_o !== 1'b1 || haddr_o !== 32'h2000) begin n_fail++; $display("FAIL se_gnt: got g=%0b a=%0h exp 1/2000", d_gnt_o, haddr_o); end
      cyc(); hready_i = 1'b0; hresp_i = 1'b1; #4;
      n_tests++; if (d_gnt_o !== 1'b0 || i_gnt_o !== 1'b0 || d_rvalid_o !== 1'b0 || htrans_o !== 2'b00) begin n_fail++; $display("FAIL se_cyc1: got g=%0b ig=%0b v=%0b t=%0h exp 0/0/0/0", d_gnt_o, i_gnt_o, d_rvalid_o, htrans_o); end
      cyc(); hready_i = 1'b1; hresp_i = 1'b1; #4;
      n_tests++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b1 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL se_cyc2: got v=%0b e=%0b d=%0h exp 1/1/0", d_rvalid_o, d_err_o, d_rdata_o); end
      n_tests++; if (d_gnt_o !== 1'b0 || htrans_o !== 2'b00) begin n_fail++; $display("FAIL se_nogrant: got g=%0b t=%0h exp 0/0", d_gnt_o, htrans_o); end
      cyc(); d_req_i = 1'b0; hresp_i = 1'b0; #4;
      n_tests++; if (d_rvalid_o !== 1'b0 || d_err_o !== 1'b0) begin n_fail++; $display("FAIL se_done: got v=%0b e=%0b exp 0/0", d_rvalid_o, d_err_o); end
   endtask

   task automatic test_illegal_be();
      cyc(); d_req_i = 1'b1; d_be_i = 4'b0101; d_addr_i = 32'h5555; hrdata_i = 32'h87654321; #4;
      n_tests++; if (d_gnt_o !== 1'b1 || htrans_o !== 2'b00) begin n_fail++; $display("FAIL be_gnt: got g=%0b t=%0h exp 1/0", d_gnt_o, htrans_o); end
      n_tests++; if (haddr_o !== 32'h2000 || hsize_o !== 3'b010) begin n_fail++; $display("FAIL be_hold: got a=%0h s=%0h exp 2000/2", haddr_o, hsize_o); end
      cyc(); d_req_i = 1'b0; d_be_i = 4'b1111; #4;
      n_tests++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b1 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL be_rsp: got v=%0b e=%0b d=%0h exp 1/1/0", d_rvalid_o, d_err_o, d_rdata_o); end
      cyc(); #4;
      n_tests++; if (d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL be_done: got v=%0b exp 0", d_rvalid_o); end
   endtask

   task automatic test_arb();
      logic [3:0] exp_d;
      logic       exp_last_i;
`ifdef OBI2AHB_RR_ARB_EN
      exp_d = 4'b0101; exp_last_i = 1'b1;
`else
      exp_d = 4'b1111; exp_last_i = 1'b0;
`endif
      apply_reset();
      cyc(); i_req_i = 1'b1; i_addr_i = 32'h80; d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b1111;
      d_addr_i = 32'h90; hready_i = 1'b1; hrdata_i = 32'h0BADF00D;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         #4;
         n_tests++; if (d_gnt_o !== exp_d[k] || i_gnt_o !== !exp_d[k]) begin n_fail++; $display("FAIL arb_gnt%0d: got d=%0b i=%0b exp d=%0b i=%0b", k, d_gnt_o, i_gnt_o, exp_d[k], !exp_d[k]); end
      end
      cyc(); i_req_i = 1'b0; d_req_i = 1'b0; #4;
      n_tests++; if (i_rvalid_o !== exp_last_i || d_rvalid_o !== !exp_last_i) begin n_fail++; $display("FAIL arb_last: got iv=%0b dv=%0b exp iv=%0b", i_rvalid_o, d_rvalid_o, exp_last_i); end
   endtask

   task automatic test_reset_mid();
      cyc(); d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b1111; d_addr_i = 32'h40; d_wdata_i = 32'hCAFEF00D; #4;
      n_tests++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %0b exp 1", d_gnt_o); end
      cyc(); d_req_i = 1'b0; hready_i = 1'b0; #4;
      n_tests++; if (d_rvalid_o !== 1'b0 || hwdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rm_wait: got v=%0b wd=%0h exp 0/cafef00d", d_rvalid_o, hwdata_o); end
      cyc(); hresetn_i = 1'b0; #4;
      n_tests++; if (hwdata_o !== 32'h0 || haddr_o !== 32'h0 || hwrite_o !== 1'b0 || hsize_o !== 3'b000) begin n_fail++; $display("FAIL rm_rst: got wd=%0h a=%0h w=%0b s=%0h exp 0", hwdata_o, haddr_o, hwrite_o, hsize_o); end
      n_tests++; if (hprot_o !== 4'b1011 || htrans_o !== 2'b00 || d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rm_rst2: got p=%0b t=%0h v=%0b exp 1011/0/0", hprot_o, htrans_o, d_rvalid_o); end
      cyc(); hresetn_i = 1'b1; hready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) cyc();
         #4;
         n_tests++; if (d_rvalid_o !== 1'b0 || i_rvalid_o !== 1'b0 || htrans_o !== 2'b00) begin n_fail++; $display("FAIL rm_stray%0d: got dv=%0b iv=%0b t=%0h exp 0/0/0", k, d_rvalid_o, i_rvalid_o, htrans_o); end
      end
   endtask

   initial begin
      hresetn_i = 1'b0; hrdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0;
      i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_addr_i = '0;
      d_we_i = 1'b0; d_be_i = 4'b1111; d_wdata_i = '0; priv_mode_i = 1'b1;
      test_reset();
      test_write_half();
      test_instr_b2b();
      test_byte_user();
      test_slave_err();
      test_illegal_be();
      test_arb();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
